// File: rtl/sprite_lb_pkg.sv
`default_nettype none
// sprite_lb_pkg: shared types and helpers for the sprite line buffer.
package sprite_lb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Per-field write enables for a bank entry {shadow, pal, pix}.
  typedef struct packed {
    logic shadow;
    logic pal;
    logic pix;
  } field_mask_t;

  localparam field_mask_t MASK_ALL    = '{shadow: 1'b1, pal: 1'b1, pix: 1'b1};
  localparam field_mask_t MASK_SHADOW = '{shadow: 1'b1, pal: 1'b0, pix: 1'b0};

  // Entry layout at the default widths; modules build their own copy from PIX_W/PAL_W.
  typedef struct packed {
    logic       shadow;
    logic [7:0] pal;
    logic [3:0] pix;
  } entry_default_t;

  function automatic int addr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_bank_ram.sv
`default_nettype none
// lb_bank_ram: one line bank -- masked-write / sync-read RAM plus per-entry occupancy flops.
module lb_bank_ram
  import sprite_lb_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int PIX_W  = 4,
  parameter int PAL_W  = 8,
  parameter int ADDR_W = 9
) (
  input  logic                     clk_24M,
  input  logic                     nRES,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [PAL_W+PIX_W:0]     wdata_i,
  input  field_mask_t              wmask_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic [PAL_W+PIX_W:0]     rdata_o,
  input  logic                     occ_set_i,
  input  logic [ADDR_W-1:0]        occ_set_addr_i,
  input  logic                     occ_clr_i,
  input  logic [ADDR_W-1:0]        occ_clr_addr_i,
  input  logic [ADDR_W-1:0]        occ_qaddr_i,
  output logic                     occ_o
);

  typedef struct packed {
    logic             shadow;
    logic [PAL_W-1:0] pal;
    logic [PIX_W-1:0] pix;
  } entry_t;

  entry_t                 mem_q [LINE_W];
  entry_t                 wdata;
  logic [PAL_W+PIX_W:0]   rdata_q;
  logic [LINE_W-1:0]      occ_q;

  assign wdata = entry_t'(wdata_i);

  always_ff @(posedge clk_24M) begin
    if (we_i) begin
      if (wmask_i.shadow) mem_q[waddr_i].shadow <= wdata.shadow;
      if (wmask_i.pal)    mem_q[waddr_i].pal    <= wdata.pal;
      if (wmask_i.pix)    mem_q[waddr_i].pix    <= wdata.pix;
    end
  end

  // Read-first: a same-cycle clear of the read address returns the old entry.
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      occ_q <= '0;
    end else begin
      if (occ_clr_i) occ_q[occ_clr_addr_i] <= 1'b0;
      if (occ_set_i) occ_q[occ_set_addr_i] <= 1'b1;
    end
  end

  assign rdata_o = rdata_q;
  assign occ_o   = occ_q[occ_qaddr_i];

endmodule
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// sprite_line_buffer: double-buffered sprite line store with bank swap, post-reset
// clear sweep, first/last-wins priority and mirrored clear-on-read display port.
module sprite_line_buffer
  import sprite_lb_pkg::*;
#(
  parameter int  LINE_W     = 512,
  parameter int  PIX_W      = 4,
  parameter int  PAL_W      = 8,
  parameter int  FIRST_WINS = 0,
  localparam int ADDR_W     = addr_w(LINE_W)
) (
  input  logic              clk_24M,
  input  logic              nRES,
  output logic              busy,
  input  logic              line_swap,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic [PAL_W-1:0]  wr_pal,
  input  logic              wr_shadow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_x,
  input  logic              rd_flip,
  output logic [PIX_W-1:0]  rd_pix,
  output logic [PAL_W-1:0]  rd_pal,
  output logic              rd_shadow,
  output logic              rd_opaque,
  output logic              wr_bank
);

  localparam int                ENTRY_W   = 1 + PAL_W + PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_W - 1);

  typedef struct packed {
    logic             shadow;
    logic [PAL_W-1:0] pal;
    logic [PIX_W-1:0] pix;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_sel_q, rd_sel_d;

  logic              run;
  logic              rd_go;
  logic              wr_occ;
  logic [ADDR_W-1:0] rd_addr;
  logic              ren_we;
  logic              ren_occ_set;
  field_mask_t       ren_mask;
  entry_t            ren_data;
  logic [1:0][ENTRY_W-1:0] bank_rdata;
  logic [1:0]        bank_occ;
  entry_t            rd_entry;

  assign run     = (state_q == RUN);
  assign busy    = ~run;
  assign rd_go   = run & rd_en;
  assign rd_addr = rd_x ^ {ADDR_W{rd_flip}};
  assign wr_occ  = bank_occ[wr_bank_q];
  assign wr_bank = wr_bank_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_sel_d  = rd_sel_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) state_d = RUN;
    end
    if (run && line_swap) wr_bank_d = ~wr_bank_q;
    // Output mux follows the bank that was last read, so idle cycles hold the value.
    if (rd_go) rd_sel_d = ~wr_bank_q;
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  always_comb begin
    ren_we      = 1'b0;
    ren_occ_set = 1'b0;
    ren_mask    = MASK_ALL;
    ren_data    = '0;
    if (rd_go | ~rd_go) begin
      if (run && wr_en) begin
        if (wr_pix != '0) begin
          if (!((FIRST_WINS != 0) && wr_occ)) begin
            ren_we      = 1'b1;
            ren_occ_set = 1'b1;
            ren_data    = '{shadow: wr_shadow, pal: wr_pal, pix: wr_pix};
          end
        end else if (wr_shadow) begin
          // Shadow-only: full blank entry when empty, shadow bit alone when occupied.
          ren_we          = 1'b1;
          ren_data.shadow = 1'b1;
          if (wr_occ) ren_mask = MASK_SHADOW;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic              is_render;
    logic              we;
    logic              re;
    logic              occ_set;
    logic              occ_clr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] clr_addr;
    entry_t            wdata;
    field_mask_t       wmask;

    assign is_render = (wr_bank_q == 1'(b));
    assign re        = rd_go & ~is_render;

    always_comb begin
      we       = 1'b0;
      waddr    = cnt_q;
      wdata    = '0;
      wmask    = MASK_ALL;
      occ_set  = 1'b0;
      occ_clr  = 1'b0;
      clr_addr = cnt_q;
      if (!run) begin
        we      = 1'b1;
        occ_clr = 1'b1;
      end else if (is_render) begin
        we      = ren_we;
        waddr   = wr_x;
        wdata   = ren_data;
        wmask   = ren_mask;
        occ_set = ren_occ_set;
      end else begin
        we       = rd_go;
        waddr    = rd_addr;
        occ_clr  = rd_go;
        clr_addr = rd_addr;
      end
    end

    lb_bank_ram #(
      .LINE_W (LINE_W),
      .PIX_W  (PIX_W),
      .PAL_W  (PAL_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk_24M        (clk_24M),
      .nRES           (nRES),
      .we_i           (we),
      .waddr_i        (waddr),
      .wdata_i        (wdata),
      .wmask_i        (wmask),
      .re_i           (re),
      .raddr_i        (rd_addr),
      .rdata_o        (bank_rdata[b]),
      .occ_set_i      (occ_set),
      .occ_set_addr_i (wr_x),
      .occ_clr_i      (occ_clr),
      .occ_clr_addr_i (clr_addr),
      .occ_qaddr_i    (wr_x),
      .occ_o          (bank_occ[b])
    );
  end

  assign rd_entry  = entry_t'(bank_rdata[rd_sel_q]);
  assign rd_pix    = rd_entry.pix;
  assign rd_pal    = rd_entry.pal;
  assign rd_shadow = rd_entry.shadow;
  assign rd_opaque = |rd_entry.pix;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_buffer.sv
`default_nettype none
// tb_sprite_line_buffer: vector table plus scoreboard of expected reads, run against
// a last-wins and a first-wins instance sharing one stimulus stream.
module tb_sprite_line_buffer;

  typedef struct packed {
    logic       sh;
    logic [7:0] pal;
    logic [3:0] pix;
  } ent_t;

  typedef struct {
    ent_t  e0;
    ent_t  e1;
    string tag;
  } sb_t;

  typedef struct {
    string      name;
    logic [3:0] x1, p1;
    logic [7:0] a1;
    logic       s1;
    logic       two;
    logic [3:0] x2, p2;
    logic [7:0] a2;
    logic       s2;
    logic [3:0] rx;
    logic       rf;
    ent_t       e0, e1;
  } vec_t;

  logic       clk_24M = 1'b0;
  logic       nRES = 1'b0;
  logic       line_swap = 1'b0, wr_en = 1'b0, wr_shadow = 1'b0, rd_en = 1'b0, rd_flip = 1'b0;
  logic [3:0] wr_x = '0, wr_pix = '0, rd_x = '0;
  logic [7:0] wr_pal = '0;

  logic       busy0, sh0, op0, wb0, busy1, sh1, op1, wb1;
  logic [3:0] pix0, pix1;
  logic [7:0] pal0, pal1;

  int   checks = 0;
  int   failures = 0;
  sb_t  sb_q[$];
  bit   rd_pend = 1'b0;
  logic exp_wb = 1'b0;
  ent_t last0 = '0, last1 = '0;
  vec_t tbl[9];

  always #5 clk_24M = ~clk_24M;

  sprite_line_buffer #(.LINE_W(16), .PIX_W(4), .PAL_W(8), .FIRST_WINS(0)) u_dut0 (
    .clk_24M(clk_24M), .nRES(nRES), .busy(busy0), .line_swap(line_swap),
    .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_shadow(wr_shadow),
    .rd_en(rd_en), .rd_x(rd_x), .rd_flip(rd_flip), .rd_pix(pix0), .rd_pal(pal0),
    .rd_shadow(sh0), .rd_opaque(op0), .wr_bank(wb0));

  sprite_line_buffer #(.LINE_W(16), .PIX_W(4), .PAL_W(8), .FIRST_WINS(1)) u_dut1 (
    .clk_24M(clk_24M), .nRES(nRES), .busy(busy1), .line_swap(line_swap),
    .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_shadow(wr_shadow),
    .rd_en(rd_en), .rd_x(rd_x), .rd_flip(rd_flip), .rd_pix(pix1), .rd_pal(pal1),
    .rd_shadow(sh1), .rd_opaque(op1), .wr_bank(wb1));

  function automatic ent_t E(input logic sh, input logic [7:0] pal, input logic [3:0] pix);
    return {sh, pal, pix};
  endfunction

  function automatic logic [13:0] outv(input ent_t e);
    return {|e.pix, e};
  endfunction

  function automatic vec_t mk(input string n, input logic [3:0] x1, p1, input logic [7:0] a1,
                              input logic s1, input logic two, input logic [3:0] p2,
                              input logic [7:0] a2, input logic s2, input logic [3:0] rx,
                              input logic rf, input ent_t e0, e1);
    vec_t v;
    v.name = n; v.x1 = x1; v.p1 = p1; v.a1 = a1; v.s1 = s1;
    v.two = two; v.x2 = x1; v.p2 = p2; v.a2 = a2; v.s2 = s2;
    v.rx = rx; v.rf = rf; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit  was;
    sb_t s;
    was = rd_pend;
    rd_pend = 1'b0;
    @(posedge clk_24M);
    #1;
    if (was && sb_q.size() > 0) begin
      s = sb_q.pop_front();
      chk({s.tag, "_fw0"}, 32'({op0, sh0, pal0, pix0}), 32'(outv(s.e0)));
      chk({s.tag, "_fw1"}, 32'({op1, sh1, pal1, pix1}), 32'(outv(s.e1)));
      last0 = s.e0;
      last1 = s.e1;
    end
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] pix, input logic [7:0] pal,
                    input logic sh);
    wr_en = 1'b1; wr_x = x; wr_pix = pix; wr_pal = pal; wr_shadow = sh;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] x, input logic f, input ent_t e0, input ent_t e1,
                    input string tag);
    sb_t s;
    s.e0 = e0; s.e1 = e1; s.tag = tag;
    rd_en = 1'b1; rd_x = x; rd_flip = f;
    sb_q.push_back(s);
    rd_pend = 1'b1;
    step();
    rd_en = 1'b0; rd_flip = 1'b0;
  endtask

  task automatic swap();
    line_swap = 1'b1;
    exp_wb = ~exp_wb;
    step();
    line_swap = 1'b0;
    chk("wr_bank", 32'({wb1, wb0}), 32'({exp_wb, exp_wb}));
  endtask

  task automatic sweep(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd16);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk("basic",     4'd5, 4'd3, 8'h2A, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd5,  1'b0, E(0, 8'h2A, 4'd3), E(0, 8'h2A, 4'd3));
    tbl[1] = mk("priority",  4'd7, 4'd2, 8'h11, 1'b0, 1'b1, 4'd9, 8'h22, 1'b0, 4'd7,  1'b0, E(0, 8'h22, 4'd9), E(0, 8'h11, 4'd2));
    tbl[2] = mk("transp",    4'd3, 4'd5, 8'h33, 1'b0, 1'b1, 4'd0, 8'hFF, 1'b0, 4'd3,  1'b0, E(0, 8'h33, 4'd5), E(0, 8'h33, 4'd5));
    tbl[3] = mk("shd_empty", 4'd1, 4'd0, 8'h77, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd1,  1'b0, E(1, 8'h00, 4'd0), E(1, 8'h00, 4'd0));
    tbl[4] = mk("shd_occ",   4'd2, 4'd4, 8'h44, 1'b0, 1'b1, 4'd0, 8'hFF, 1'b1, 4'd2,  1'b0, E(1, 8'h44, 4'd4), E(1, 8'h44, 4'd4));
    tbl[5] = mk("flip",      4'd0, 4'd6, 8'h05, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd15, 1'b1, E(0, 8'h05, 4'd6), E(0, 8'h05, 4'd6));
    tbl[6] = mk("prio_shd",  4'd9, 4'hF, 8'h80, 1'b1, 1'b1, 4'd1, 8'h01, 1'b0, 4'd9,  1'b0, E(0, 8'h01, 4'd1), E(1, 8'h80, 4'hF));
    tbl[7] = mk("shd_then_op", 4'd4, 4'd0, 8'h00, 1'b1, 1'b1, 4'd8, 8'h12, 1'b0, 4'd4, 1'b0, E(0, 8'h12, 4'd8), E(0, 8'h12, 4'd8));
    tbl[8] = mk("last_addr", 4'd15, 4'd7, 8'hC3, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd15, 1'b0, E(0, 8'hC3, 4'd7), E(0, 8'hC3, 4'd7));

    // Reset state
    step();
    step();
    chk("rst_busy", 32'({busy1, busy0}), 32'h3);
    chk("rst_out0", 32'({op0, sh0, pal0, pix0}), 32'd0);
    chk("rst_out1", 32'({op1, sh1, pal1, pix1}), 32'd0);
    chk("rst_wr_bank", 32'({wb1, wb0}), 32'd0);

    nRES = 1'b1;
    sweep("sweep_len");

    for (int i = 0; i < 16; i++) rd(4'(i), 1'b0, '0, '0, "blank_b1");
    swap();
    for (int i = 0; i < 16; i++) rd(4'(i), 1'b0, '0, '0, "blank_b0");

    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].x1, tbl[i].p1, tbl[i].a1, tbl[i].s1);
      if (tbl[i].two) wr(tbl[i].x2, tbl[i].p2, tbl[i].a2, tbl[i].s2);
      swap();
      rd(tbl[i].rx, tbl[i].rf, tbl[i].e0, tbl[i].e1, tbl[i].name);
    end

    // Outputs hold while rd_en is low
    step();
    step();
    chk("hold0", 32'({op0, sh0, pal0, pix0}), 32'(outv(last0)));
    chk("hold1", 32'({op1, sh1, pal1, pix1}), 32'(outv(last1)));

    // Clear-on-read
    wr(4'd5, 4'd3, 8'h2A, 1'b0);
    swap();
    rd(4'd5, 1'b0, E(0, 8'h2A, 4'd3), E(0, 8'h2A, 4'd3), "cor_first");
    swap();
    swap();
    rd(4'd5, 1'b0, '0, '0, "cor_second");

    // Unread entries persist across swaps
    wr(4'd10, 4'd2, 8'h3C, 1'b0);
    swap();
    swap();
    swap();
    rd(4'd10, 1'b0, E(0, 8'h3C, 4'd2), E(0, 8'h3C, 4'd2), "persist");

    // Pipelined reads
    wr(4'd11, 4'd1, 8'h01, 1'b0);
    wr(4'd12, 4'd2, 8'h02, 1'b0);
    wr(4'd13, 4'd3, 8'h03, 1'b0);
    swap();
    rd(4'd11, 1'b0, E(0, 8'h01, 4'd1), E(0, 8'h01, 4'd1), "pipe11");
    rd(4'd12, 1'b0, E(0, 8'h02, 4'd2), E(0, 8'h02, 4'd2), "pipe12");
    rd(4'd13, 1'b0, E(0, 8'h03, 4'd3), E(0, 8'h03, 4'd3), "pipe13");

    // Swap, write and read in one cycle use the old bank roles
    wr(4'd6, 4'd5, 8'h50, 1'b0);
    swap();
    begin
      sb_t s;
      s.e0 = E(0, 8'h50, 4'd5); s.e1 = s.e0; s.tag = "simul_rd";
      line_swap = 1'b1;
      wr_en = 1'b1; wr_x = 4'd6; wr_pix = 4'hA; wr_pal = 8'hA0; wr_shadow = 1'b0;
      rd_en = 1'b1; rd_x = 4'd6; rd_flip = 1'b0;
      sb_q.push_back(s);
      rd_pend = 1'b1;
      exp_wb = ~exp_wb;
      step();
      line_swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      chk("simul_wr_bank", 32'({wb1, wb0}), 32'({exp_wb, exp_wb}));
    end
    rd(4'd6, 1'b0, E(0, 8'hA0, 4'hA), E(0, 8'hA0, 4'hA), "simul_wr");

    // Back-to-back swaps
    swap();
    swap();
    swap();

    // Reset mid-line
    if (exp_wb) swap();
    wr(4'd8, 4'd3, 8'h33, 1'b0);
    swap();
    rd(4'd8, 1'b0, E(0, 8'h33, 4'd3), E(0, 8'h33, 4'd3), "pre_reset");
    wr(4'd8, 4'd5, 8'h55, 1'b0);
    #3;
    nRES = 1'b0;
    #1;
    exp_wb = 1'b0;
    chk("mid_rst_busy", 32'({busy1, busy0}), 32'h3);
    chk("mid_rst_out0", 32'({op0, sh0, pal0, pix0}), 32'd0);
    chk("mid_rst_out1", 32'({op1, sh1, pal1, pix1}), 32'd0);
    chk("mid_rst_wr_bank", 32'({wb1, wb0}), 32'd0);
    step();
    step();
    nRES = 1'b1;
    rd_en = 1'b1; rd_x = 4'd8;
    wr_en = 1'b1; wr_x = 4'd3; wr_pix = 4'd5; wr_pal = 8'h5A;
    line_swap = 1'b1;
    begin
      int n;
      n = 0;
      while (busy0 && n < 100) begin
        step();
        n++;
        chk("init_ignore", 32'({wb1, wb0, op1, pix1, op0, pix0, pal0}), 32'd0);
      end
      chk("resweep_len", 32'(n), 32'd16);
    end
    rd_en = 1'b0; wr_en = 1'b0; line_swap = 1'b0;
    rd(4'd8, 1'b0, '0, '0, "post_rst_b1");
    swap();
    rd(4'd3, 1'b0, '0, '0, "post_rst_b0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
